// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Central stall/flush controller for the 5-stage MIPS pipeline.
//   * Detects load-use hazards between the load in EX and the ID register reads,
//     and holds PC/IF/ID for one cycle so EX receives exactly one bubble.
//   * Sequences multi-cycle DIV/DIVU in EX.  It counts the busy time internally
//     and holds PC..EX until the result is ready.
//   * Turns a MEM-stage exception/ERET into a single-cycle flush of every
//     pipeline register.  Any DIV in flight is aborted.
//   * Keeps a saturating count of cycles in which any stage was stalled.
//
// Parameters
//   DIV_CYCLES  EX occupancy of one DIV, including the start cycle (2..255).
//   CNT_W       width of the stall-cycle performance counter.
//
// Ports
//   clk             in   rising-edge clock
//   rstn            in   asynchronous reset, active-HIGH (legacy naming)
//   i_id_reg1_read  in   ID reads source 1
//   i_id_reg1_addr  in   ID source-1 register address
//   i_id_reg2_read  in   ID reads source 2
//   i_id_reg2_addr  in   ID source-2 register address
//   i_ex_mem_to_reg in   instruction in EX is a load
//   i_ex_wd         in   destination register of the instruction in EX
//   i_ex_div_start  in   instruction in EX is DIV/DIVU (honoured in RUN only)
//   i_exc_req       in   MEM raises an exception/ERET this cycle
//   o_stall         out  per-stage hold: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
//                        (combinational)
//   o_flush         out  clear all pipeline registers (combinational pulse)
//   o_div_busy      out  registered, high while a DIV occupies EX
//   o_div_done      out  registered one-cycle pulse, DIV result valid in EX
//   o_stall_cycles  out  saturating count of cycles with o_stall != 0
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_id_reg1_read,
  input  logic [4:0]       i_id_reg1_addr,
  input  logic             i_id_reg2_read,
  input  logic [4:0]       i_id_reg2_addr,
  input  logic             i_ex_mem_to_reg,
  input  logic [4:0]       i_ex_wd,
  input  logic             i_ex_div_start,
  input  logic             i_exc_req,
  output logic [5:0]       o_stall,
  output logic             o_flush,
  output logic             o_div_busy,
  output logic             o_div_done,
  output logic [CNT_W-1:0] o_stall_cycles
);

  // FSM encoding kept as plain constants for compatibility with older tools.
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_DIV = 1'b1;

  // Stall patterns.  A load-use hazard holds PC/IF/ID while EX advances, which
  // injects one bubble.  A DIV additionally holds EX so the divider keeps its
  // operands.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LOAD = 6'b000111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;

  // The start cycle and the final (unstalled) result cycle are not counted in
  // r_cnt, so the count loaded on entry is DIV_CYCLES-2.
  localparam logic [7:0]       DIV_LOAD = 8'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // State registers
  logic [0:0]       r_state;
  logic [7:0]       r_cnt;
  logic             r_div_busy;
  logic             r_div_done;
  logic [CNT_W-1:0] r_stall_cycles;

  // Combinational decode
  logic             w_src1_hit;
  logic             w_src2_hit;
  logic             w_load_use;
  logic [5:0]       w_stall;
  logic             w_flush;
  logic [0:0]       w_next_state;
  logic [7:0]       w_next_cnt;
  logic             w_next_done;
  logic             w_count_en;

  // Register $0 is hard-wired to zero, so a load targeting it is never a
  // real producer and must not stall.
  assign w_src1_hit = i_id_reg1_read && (i_id_reg1_addr == i_ex_wd);
  assign w_src2_hit = i_id_reg2_read && (i_id_reg2_addr == i_ex_wd);
  assign w_load_use = i_ex_mem_to_reg && (i_ex_wd != 5'd0) &&
                      (w_src1_hit || w_src2_hit);

  // Priority: exception > DIV in progress > DIV start > load-use.
  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_stall      = STALL_NONE;
    w_flush      = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_done  = 1'b0;

    if (i_exc_req) begin
      w_flush      = 1'b1;
      w_next_state = ST_RUN;
      w_next_cnt   = 8'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_ex_div_start) begin
            w_stall      = STALL_DIV;
            w_next_state = ST_DIV;
            w_next_cnt   = DIV_LOAD;
            // With the minimum latency the very next cycle is the result cycle.
            w_next_done  = (DIV_LOAD == 8'd0);
          end else if (w_load_use) begin
            w_stall = STALL_LOAD;
          end
        end
        ST_DIV: begin
          // A new DIV start and any load-use hazard are ignored here.  On the
          // result cycle (cnt==0) the pipeline is released even if the
          // consumer in ID would otherwise look like a hazard.
          if (r_cnt != 8'd0) begin
            w_stall     = STALL_DIV;
            w_next_cnt  = r_cnt - 8'd1;
            // div_done is registered but must be high on the result cycle
            // itself, so it is armed one cycle ahead.
            w_next_done = (r_cnt == 8'd1);
          end else begin
            w_next_state = ST_RUN;
          end
        end
        default: begin
          w_next_state = ST_RUN;
          w_next_cnt   = 8'd0;
        end
      endcase
    end
  end

  // The combinational outputs are forced quiet while reset is held so that the
  // pipeline registers see a clean hold-free, flush-free reset.
  assign o_stall = rstn ? STALL_NONE : w_stall;
  assign o_flush = rstn ? 1'b0       : w_flush;

  // Flush cycles carry stall==0, so they are naturally excluded from the count.
  assign w_count_en = (o_stall != STALL_NONE) && (r_stall_cycles != CNT_MAX);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state        <= ST_RUN;
      r_cnt          <= 8'd0;
      r_div_busy     <= 1'b0;
      r_div_done     <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_div_busy <= (w_next_state == ST_DIV);
      r_div_done <= w_next_done;
      if (w_count_en) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign o_div_busy     = r_div_busy;
  assign o_div_done     = r_div_done;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//
// Self-checking bench for pipe_stall_ctrl.  The main instance uses the default
// DIV_CYCLES=32 / CNT_W=32.  A second instance with DIV_CYCLES=2 / CNT_W=3
// exercises the minimum divide latency and counter saturation.  The reference
// model tracks "DIV occupancy cycles remaining" and a saturating stall count.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned CNT_W      = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // Main instance stimulus / observation
  logic              r1_read, r2_read, mem_to_reg, div_start, exc;
  logic [4:0]        r1_addr, r2_addr, wd;
  logic [5:0]        stall;
  logic              flush, div_busy, div_done;
  logic [CNT_W-1:0]  stall_cycles;

  // Small instance stimulus / observation
  logic              s_r1_read, s_r2_read, s_mem_to_reg, s_div_start, s_exc;
  logic [4:0]        s_r1_addr, s_r2_addr, s_wd;
  logic [5:0]        s_stall;
  logic              s_flush, s_div_busy, s_div_done;
  logic [2:0]        s_stall_cycles;

  pipe_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_id_reg1_read (r1_read),
    .i_id_reg1_addr (r1_addr),
    .i_id_reg2_read (r2_read),
    .i_id_reg2_addr (r2_addr),
    .i_ex_mem_to_reg(mem_to_reg),
    .i_ex_wd        (wd),
    .i_ex_div_start (div_start),
    .i_exc_req      (exc),
    .o_stall        (stall),
    .o_flush        (flush),
    .o_div_busy     (div_busy),
    .o_div_done     (div_done),
    .o_stall_cycles (stall_cycles)
  );

  pipe_stall_ctrl #(.DIV_CYCLES(2), .CNT_W(3)) dut_small (
    .clk            (clk),
    .rstn           (rstn),
    .i_id_reg1_read (s_r1_read),
    .i_id_reg1_addr (s_r1_addr),
    .i_id_reg2_read (s_r2_read),
    .i_id_reg2_addr (s_r2_addr),
    .i_ex_mem_to_reg(s_mem_to_reg),
    .i_ex_wd        (s_wd),
    .i_ex_div_start (s_div_start),
    .i_exc_req      (s_exc),
    .o_stall        (s_stall),
    .o_flush        (s_flush),
    .o_div_busy     (s_div_busy),
    .o_div_done     (s_div_done),
    .o_stall_cycles (s_stall_cycles)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   m_left : DIV occupancy cycles still to come (0 = not dividing).  The last
  //            one is the unstalled result cycle.
  //   m_cnt  : saturating count of stalled cycles.
  // ---------------------------------------------------------------------------
  int               m_left;
  logic [CNT_W-1:0] m_cnt;

  function automatic logic model_load_use();
    return mem_to_reg && (wd != 5'd0) &&
           ((r1_read && r1_addr == wd) || (r2_read && r2_addr == wd));
  endfunction

  // Called just after a rising edge with inputs already applied: predicts this
  // cycle's outputs, compares them mid-cycle, then advances the model.
  task automatic step(input string nm);
    logic [5:0] es;
    logic       ef;
    logic       eb, ed;
    es = 6'b000000;
    ef = 1'b0;
    eb = (m_left > 0);
    ed = (m_left == 1);
    if (exc)              ef = 1'b1;
    else if (m_left > 1)  es = 6'b001111;
    else if (m_left == 1) es = 6'b000000;
    else if (div_start)   es = 6'b001111;
    else if (model_load_use()) es = 6'b000111;

    @(negedge clk);
    check({nm, ".stall"}, 64'(stall), 64'(es));
    check({nm, ".flush"}, 64'(flush), 64'(ef));
    check({nm, ".busy"},  64'(div_busy), 64'(eb));
    check({nm, ".done"},  64'(div_done), 64'(ed));
    check({nm, ".cnt"},   64'(stall_cycles), 64'(m_cnt));

    @(posedge clk);
    if (es != 6'b0 && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    if (exc)             m_left = 0;
    else if (m_left > 0) m_left = m_left - 1;
    else if (div_start)  m_left = DIV_CYCLES - 1;
    #1;
  endtask

  task automatic idle_inputs();
    r1_read = 1'b0; r1_addr = 5'd0; r2_read = 1'b0; r2_addr = 5'd0;
    mem_to_reg = 1'b0; wd = 5'd0; div_start = 1'b0; exc = 1'b0;
  endtask

  task automatic set_hazard(input logic [4:0] reg_no);
    r2_read = 1'b1; r2_addr = reg_no; mem_to_reg = 1'b1; wd = reg_no;
  endtask

  // ---------------------------------------------------------------------------
  // Single-cycle vector table, applied from RUN state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       r1_rd;
    logic [4:0] r1_a;
    logic       r2_rd;
    logic [4:0] r2_a;
    logic       m2r;
    logic [4:0] wd;
    logic       exc;
    logic [5:0] exp_stall;
    logic       exp_flush;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  1'b1, 5'd5, 1'b1, 5'd5,  1'b0, 6'b000111, 1'b0}; // src2 hazard
    vecs[1]  = '{1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 6'b000000, 1'b0}; // bubble follows
    vecs[2]  = '{1'b0, 5'd0,  1'b1, 5'd5, 1'b1, 5'd0,  1'b0, 6'b000000, 1'b0}; // load to $0
    vecs[3]  = '{1'b1, 5'd7,  1'b0, 5'd0, 1'b1, 5'd7,  1'b0, 6'b000111, 1'b0}; // src1 hazard
    vecs[4]  = '{1'b0, 5'd7,  1'b0, 5'd7, 1'b1, 5'd7,  1'b0, 6'b000000, 1'b0}; // no reads
    vecs[5]  = '{1'b1, 5'd3,  1'b1, 5'd9, 1'b0, 5'd9,  1'b0, 6'b000000, 1'b0}; // not a load
    vecs[6]  = '{1'b1, 5'd3,  1'b1, 5'd9, 1'b1, 5'd9,  1'b0, 6'b000111, 1'b0}; // src2 only
    vecs[7]  = '{1'b1, 5'd0,  1'b1, 5'd0, 1'b1, 5'd0,  1'b0, 6'b000000, 1'b0}; // $0 reads
    vecs[8]  = '{1'b1, 5'd31, 1'b0, 5'd0, 1'b1, 5'd31, 1'b0, 6'b000111, 1'b0}; // top reg
    vecs[9]  = '{1'b1, 5'd4,  1'b1, 5'd6, 1'b1, 5'd5,  1'b0, 6'b000000, 1'b0}; // mismatch
    vecs[10] = '{1'b0, 5'd0,  1'b1, 5'd5, 1'b1, 5'd5,  1'b1, 6'b000000, 1'b1}; // exc beats hazard
    vecs[11] = '{1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 6'b000000, 1'b1}; // exc alone

    // Small instance idle
    s_r1_read = 1'b0; s_r1_addr = 5'd0; s_r2_read = 1'b0; s_r2_addr = 5'd0;
    s_mem_to_reg = 1'b0; s_wd = 5'd0; s_div_start = 1'b0; s_exc = 1'b0;

    // ---- Reset: outputs quiet even with a hazard on the inputs ----
    rstn = 1'b1;
    idle_inputs();
    set_hazard(5'd5);
    repeat (2) @(posedge clk);
    #1;
    check("rst.stall", 64'(stall), 64'd0);
    check("rst.flush", 64'(flush), 64'd0);
    check("rst.busy",  64'(div_busy), 64'd0);
    check("rst.done",  64'(div_done), 64'd0);
    check("rst.cnt",   64'(stall_cycles), 64'd0);
    idle_inputs();
    rstn = 1'b0;
    m_left = 0;
    m_cnt  = '0;
    @(posedge clk); #1;

    // ---- Full DIV: 31 stalled cycles, result on cycle 32 ----
    div_start = 1'b1;
    step("div.start");
    div_start = 1'b0;
    for (int i = 2; i <= 31; i++) step("div.run");
    check("div.c32.stall", 64'(stall), 64'd0);
    check("div.c32.done",  64'(div_done), 64'd1);
    check("div.c32.busy",  64'(div_busy), 64'd1);
    step("div.c32");
    check("div.total_stalls", 64'(stall_cycles), 64'd31);
    check("div.after.busy", 64'(div_busy), 64'd0);
    step("div.after");

    // ---- Table-driven single-cycle vectors ----
    for (int i = 0; i < 12; i++) begin
      r1_read = vecs[i].r1_rd; r1_addr = vecs[i].r1_a;
      r2_read = vecs[i].r2_rd; r2_addr = vecs[i].r2_a;
      mem_to_reg = vecs[i].m2r; wd = vecs[i].wd; exc = vecs[i].exc;
      div_start = 1'b0;
      #1;
      check($sformatf("vec%0d.stall", i), 64'(stall), 64'(vecs[i].exp_stall));
      check($sformatf("vec%0d.flush", i), 64'(flush), 64'(vecs[i].exp_flush));
      step($sformatf("vec%0d", i));
    end
    idle_inputs();

    // ---- Exception abort on the 5th DIV cycle ----
    div_start = 1'b1;
    step("abort.c1");
    div_start = 1'b0;
    for (int i = 2; i <= 4; i++) step("abort.run");
    exc = 1'b1;
    #1;
    check("abort.flush", 64'(flush), 64'd1);
    check("abort.stall", 64'(stall), 64'd0);
    step("abort.c5");
    exc = 1'b0;
    check("abort.next.busy", 64'(div_busy), 64'd0);
    check("abort.next.done", 64'(div_done), 64'd0);
    for (int i = 0; i < 30; i++) step("abort.quiet");

    // ---- Priority: DIV start beats load-use ----
    set_hazard(5'd8);
    div_start = 1'b1;
    #1;
    check("prio.div.stall", 64'(stall), 64'h0f);
    step("prio.div");
    div_start = 1'b0;
    check("prio.div.busy", 64'(div_busy), 64'd1);
    // Hazard held throughout: ignored in DIV, including the result cycle
    for (int i = 0; i < 64 && m_left > 0; i++) step("prio.drain");
    idle_inputs();

    // ---- Async reset mid-DIV with cnt=10 (20 DIV cycles after start) ----
    div_start = 1'b1;
    step("mrst.start");
    div_start = 1'b0;
    for (int i = 0; i < 20; i++) step("mrst.run");
    #2;
    rstn = 1'b1;
    #1;
    check("mrst.stall", 64'(stall), 64'd0);
    check("mrst.busy",  64'(div_busy), 64'd0);
    check("mrst.cnt",   64'(stall_cycles), 64'd0);
    m_left = 0;
    m_cnt  = '0;
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    set_hazard(5'd12);
    #1;
    check("mrst.run.stall", 64'(stall), 64'h07);
    step("mrst.run");
    idle_inputs();

    // ---- Randomized traffic against the model ----
    for (int i = 0; i < 1500; i++) begin
      r1_read    = 1'($urandom_range(0, 1));
      r1_addr    = 5'($urandom_range(0, 3));
      r2_read    = 1'($urandom_range(0, 1));
      r2_addr    = 5'($urandom_range(0, 3));
      mem_to_reg = 1'($urandom_range(0, 1));
      wd         = 5'($urandom_range(0, 3));
      div_start  = ($urandom_range(0, 19) == 0);
      exc        = ($urandom_range(0, 49) == 0);
      step("rand");
    end
    idle_inputs();

    // ---- Small instance: saturation at 3'b111 with load-use held ----
    s_r2_read = 1'b1; s_r2_addr = 5'd5; s_mem_to_reg = 1'b1; s_wd = 5'd5;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("sat%0d.cnt", i), 64'(s_stall_cycles), 64'((i < 7) ? i : 7));
      check($sformatf("sat%0d.stall", i), 64'(s_stall), 64'h07);
      @(posedge clk); #1;
    end
    s_r2_read = 1'b0; s_mem_to_reg = 1'b0;

    // ---- Small instance: minimum DIV latency (DIV_CYCLES=2) ----
    s_div_start = 1'b1;
    #1;
    check("min.start.stall", 64'(s_stall), 64'h0f);
    @(posedge clk); #1;
    s_div_start = 1'b0;
    #1;
    check("min.res.stall", 64'(s_stall), 64'd0);
    check("min.res.busy",  64'(s_div_busy), 64'd1);
    check("min.res.done",  64'(s_div_done), 64'd1);
    @(posedge clk); #1;
    check("min.after.busy", 64'(s_div_busy), 64'd0);
    check("min.after.done", 64'(s_div_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
